fpu_ss_instr_buffer: RTL and testbench

Instruction input buffer of the FPU subsystem. It captures offloaded instructions from the CV-X-IF issue stage and holds them in order. It presents the oldest entry to the subsystem controller through a valid/ready pop handshake. Occupancy, flush and an optional fall-through path are provided; payload contents are opaque to the block.

---
 rtl/fpu_ss_instr_buffer.sv | 93 +++++++++
 tb/tb_fpu_ss_instr_buffer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_ss_instr_buffer.sv
// FPU subsystem instruction input buffer.
// Holds instructions offloaded by the CV-X-IF issue stage in order and hands
// the oldest one to the subsystem controller through a valid/ready pop port.
// Payload bits are opaque here; only ordering and occupancy are managed.
module fpu_ss_instr_buffer #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned DATA_WIDTH   = 64,
    parameter bit          FALL_THROUGH = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_valid_i,
    output logic                       push_ready_o,
    input  logic [DATA_WIDTH-1:0]      push_data_i,
    output logic                       pop_valid_o,
    input  logic                       pop_ready_i,
    output logic [DATA_WIDTH-1:0]      pop_data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      cnt;

    logic push_hs;
    logic pop_hs;
    logic bypass;
    logic do_write;
    logic do_read;

    // Status flags come from the registered counter only, so they lag a handshake by one cycle.
    always_comb begin
        full_o  = (cnt == DEPTH_CNT);
        empty_o = (cnt == '0);
        count_o = cnt;
    end

    // Handshakes and output muxing; push_ready never looks at pop_ready so no pop credit when full.
    always_comb begin
        push_ready_o = ~full_o & ~flush_i & ~rst_i;
        pop_valid_o  = ~flush_i & ~rst_i & (~empty_o | (FALL_THROUGH & push_valid_i));
        pop_data_o   = mem[rd_ptr];
        if (FALL_THROUGH && empty_o) begin
            pop_data_o = push_data_i;
        end
        push_hs  = push_valid_i & push_ready_o;
        pop_hs   = pop_valid_o & pop_ready_i;
        // An empty buffer that pushes and pops at once just forwards the payload.
        bypass   = push_hs & pop_hs & empty_o;
        do_write = push_hs & ~bypass;
        do_read  = pop_hs & ~bypass;
    end

    // Pointer and occupancy bookkeeping; reset and flush both discard everything in one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_read) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_write && !do_read) begin
                cnt <= cnt + CNT_ONE;
            end else if (do_read && !do_write) begin
                cnt <= cnt - CNT_ONE;
            end
        end
    end

    // Payload storage; write is already gated off by reset/flush through push_ready.
    always_ff @(posedge clk_i) begin
        if (do_write) begin
            mem[wr_ptr] <= push_data_i;
        end
    end

endmodule

// File: tb/tb_fpu_ss_instr_buffer.sv
// Scoreboard bench for fpu_ss_instr_buffer: a registered-only instance and a
// fall-through instance, directed stimulus, monitors compare popped payloads.
module tb_fpu_ss_instr_buffer;

    localparam int DEPTH = 4;
    localparam int DW    = 64;

    logic          clk;
    logic          rst;

    logic          push_valid;
    logic          push_ready;
    logic [DW-1:0] push_data;
    logic          pop_valid;
    logic          pop_ready;
    logic [DW-1:0] pop_data;
    logic [2:0]    count;
    logic          full;
    logic          empty;
    logic          flush;

    logic          ft_push_valid;
    logic          ft_push_ready;
    logic [DW-1:0] ft_push_data;
    logic          ft_pop_valid;
    logic          ft_pop_ready;
    logic [DW-1:0] ft_pop_data;
    logic [2:0]    ft_count;
    logic          ft_full;
    logic          ft_empty;
    logic          ft_flush;

    int            n_checks;
    int            n_errors;
    int            model_cnt;
    int            ft_cnt;
    bit            regs_known;
    logic [DW-1:0] sb_q[$];
    logic [DW-1:0] ft_q[$];

    fpu_ss_instr_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .FALL_THROUGH(1'b0)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .push_valid_i (push_valid),
        .push_ready_o (push_ready),
        .push_data_i  (push_data),
        .pop_valid_o  (pop_valid),
        .pop_ready_i  (pop_ready),
        .pop_data_o   (pop_data),
        .count_o      (count),
        .full_o       (full),
        .empty_o      (empty)
    );

    fpu_ss_instr_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .FALL_THROUGH(1'b1)) dut_ft (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (ft_flush),
        .push_valid_i (ft_push_valid),
        .push_ready_o (ft_push_ready),
        .push_data_i  (ft_push_data),
        .pop_valid_o  (ft_pop_valid),
        .pop_ready_i  (ft_pop_ready),
        .pop_data_o   (ft_pop_data),
        .count_o      (ft_count),
        .full_o       (ft_full),
        .empty_o      (ft_empty)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Main-instance monitor: every accepted pop must match the head of the scoreboard.
    always @(negedge clk) begin
        if (pop_valid === 1'b1 && pop_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("[TB] FAIL pop_unexpected: got %0h, expected no pop", pop_data);
            end else begin
                check_output("pop_data", pop_data, sb_q.pop_front());
            end
        end
    end

    // Fall-through-instance monitor.
    always @(negedge clk) begin
        if (ft_pop_valid === 1'b1 && ft_pop_ready === 1'b1) begin
            if (ft_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("[TB] FAIL ft_pop_unexpected: got %0h, expected no pop", ft_pop_data);
            end else begin
                check_output("ft_pop_data", ft_pop_data, ft_q.pop_front());
            end
        end
    end

    // One cycle on the registered-only instance; fall-through instance idles.
    task automatic apply_stimulus(input logic pv, input logic [DW-1:0] pd, input logic pr,
                                  input logic fl, input logic rs);
        logic exp_pr;
        logic exp_pv;
        logic acc;
        logic pop;
        push_valid    = pv;
        push_data     = pd;
        pop_ready     = pr;
        flush         = fl;
        rst           = rs;
        ft_push_valid = 1'b0;
        ft_pop_ready  = 1'b0;
        exp_pr = (model_cnt < DEPTH) && !fl && !rs;
        exp_pv = (model_cnt > 0) && !fl && !rs;
        acc    = pv && exp_pr;
        pop    = pr && exp_pv;
        if (acc) sb_q.push_back(pd);
        @(negedge clk);
        check_output("push_ready", DW'(push_ready), DW'(exp_pr));
        check_output("pop_valid", DW'(pop_valid), DW'(exp_pv));
        if (regs_known) begin
            check_output("count", DW'(count), DW'(model_cnt));
            check_output("full", DW'(full), DW'(model_cnt == DEPTH));
            check_output("empty", DW'(empty), DW'(model_cnt == 0));
        end
        #1;
        if (rs || fl) begin
            model_cnt  = 0;
            sb_q.delete();
            regs_known = 1'b1;
            if (rs) begin
                ft_cnt = 0;
                ft_q.delete();
            end
        end else begin
            model_cnt = model_cnt + int'(acc) - int'(pop);
        end
        @(posedge clk);
        #1;
    endtask

    // One cycle on the fall-through instance; main instance idles.
    task automatic ft_step(input logic pv, input logic [DW-1:0] pd, input logic pr);
        logic exp_pr;
        logic exp_pv;
        logic acc;
        logic pop;
        push_valid    = 1'b0;
        pop_ready     = 1'b0;
        flush         = 1'b0;
        rst           = 1'b0;
        ft_push_valid = pv;
        ft_push_data  = pd;
        ft_pop_ready  = pr;
        exp_pr = (ft_cnt < DEPTH);
        exp_pv = (ft_cnt > 0) || pv;
        acc    = pv && exp_pr;
        pop    = pr && exp_pv;
        if (acc) ft_q.push_back(pd);
        @(negedge clk);
        check_output("ft_push_ready", DW'(ft_push_ready), DW'(exp_pr));
        check_output("ft_pop_valid", DW'(ft_pop_valid), DW'(exp_pv));
        check_output("ft_count", DW'(ft_count), DW'(ft_cnt));
        #1;
        ft_cnt = ft_cnt + int'(acc) - int'(pop);
        @(posedge clk);
        #1;
    endtask

    int gaps[10] = '{0, 1, 2, 0, 3, 1, 0, 2, 1, 0};

    // Directed sequence: reset, fill, drain, wrap, simultaneous, flush, reset, fall-through.
    initial begin
        n_checks      = 0;
        n_errors      = 0;
        model_cnt     = 0;
        ft_cnt        = 0;
        regs_known    = 1'b0;
        push_valid    = 1'b0;
        push_data     = '0;
        pop_ready     = 1'b0;
        flush         = 1'b0;
        rst           = 1'b1;
        ft_push_valid = 1'b0;
        ft_push_data  = '0;
        ft_pop_ready  = 1'b0;
        ft_flush      = 1'b0;

        apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);

        apply_stimulus(1'b1, 64'hA, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 64'hB, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 64'hC, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 64'hD, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 64'hE, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

        apply_stimulus(1'b1, 64'h1000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b1, 64'h1100 + 64'(i), 1'b0, 1'b0, 1'b0);
            for (int g = 0; g < gaps[i]; g++) apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
            apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end

        apply_stimulus(1'b1, 64'h2001, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 64'h2002, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

        apply_stimulus(1'b1, 64'h3001, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 64'h3002, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 64'h3003, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 64'h30FF, 1'b1, 1'b1, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 64'h3100, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);

        apply_stimulus(1'b1, 64'h4001, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 64'h4002, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 64'h4003, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 64'h40FF, 1'b1, 1'b0, 1'b1);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 64'h4100, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);

        ft_step(1'b1, 64'hDEAD, 1'b1);
        ft_step(1'b0, '0, 1'b0);
        ft_step(1'b1, 64'hBEEF, 1'b0);
        ft_step(1'b1, 64'hCAFE, 1'b1);
        ft_step(1'b0, '0, 1'b1);
        ft_step(1'b0, '0, 1'b0);

        check_output("sb_leftover", 64'(sb_q.size()), 64'd0);
        check_output("ft_leftover", 64'(ft_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
